// File: rtl/clint_cmp_sched.sv
// clint_cmp_sched: per-hart mtimecmp registers sharing one round-robin 64-bit >= comparator.
// Every mtime tick or mtimecmp write triggers a full scan; events during a scan queue one rescan.
module clint_cmp_sched #(
  parameter int HART_NUM = 4,
  localparam int IDX_W = (HART_NUM > 1) ? $clog2(HART_NUM) : 1
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [63:0]         mtime_i,
  input  logic                mtime_tick_i,
  input  logic [HART_NUM-1:0] cmp_wr_i,
  input  logic                cmp_wr_hi_i,
  input  logic [31:0]         cmp_wdata_i,
  input  logic [IDX_W-1:0]    cmp_rd_sel_i,
  input  logic                cmp_rd_hi_i,
  output logic [31:0]         cmp_rd_data_o,
  output logic [HART_NUM-1:0] tmr_irq_o,
  output logic                scan_busy_o
);
  typedef enum logic {IDLE, SCAN} state_t;

  logic [63:0]         r_cmp [HART_NUM];
  logic [63:0]         r_snap;
  logic [IDX_W-1:0]    r_idx;
  logic                r_pend;
  logic [HART_NUM-1:0] r_irq;
  state_t              r_state;
  logic                w_ev;
  logic                w_last;
  logic                w_rd_ok;
  logic [63:0]         w_rd_cmp;

  assign w_ev     = mtime_tick_i | (|cmp_wr_i);
  assign w_last   = (r_idx == IDX_W'(HART_NUM - 1));
  assign w_rd_ok  = ({1'b0, cmp_rd_sel_i} < (IDX_W + 1)'(HART_NUM));
  assign w_rd_cmp = r_cmp[cmp_rd_sel_i];

  assign cmp_rd_data_o = !w_rd_ok ? 32'h0 : (cmp_rd_hi_i ? w_rd_cmp[63:32] : w_rd_cmp[31:0]);
  assign tmr_irq_o     = r_irq;
  assign scan_busy_o   = (r_state == SCAN);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int h = 0; h < HART_NUM; h++) r_cmp[h] <= '1;
    end else begin
      for (int h = 0; h < HART_NUM; h++)
        if (cmp_wr_i[h]) begin
          if (cmp_wr_hi_i) r_cmp[h][63:32] <= cmp_wdata_i;
          else r_cmp[h][31:0] <= cmp_wdata_i;
        end
    end
  end

  // The compare sees the pre-write value; any concurrent write leaves r_pend set so a rescan follows.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_pend  <= 1'b0;
      r_snap  <= '0;
      r_irq   <= '0;
    end else if (r_state == IDLE) begin
      if (w_ev | r_pend) begin
        r_state <= SCAN;
        r_snap  <= mtime_i;
        r_idx   <= '0;
        r_pend  <= 1'b0;
      end
    end else begin
      r_irq[r_idx] <= (r_snap >= r_cmp[r_idx]);
      if (!w_last) begin
        r_idx <= r_idx + IDX_W'(1);
        if (w_ev) r_pend <= 1'b1;
      end else if (w_ev | r_pend) begin
        r_snap <= mtime_i;
        r_idx  <= '0;
        r_pend <= 1'b0;
      end else begin
        r_state <= IDLE;
      end
    end
  end
endmodule
